voice_cmd_tx: RTL and testbench
===============================

# voice_cmd_tx

Command-stream transmitter that drives the shared voice command bus (32-bit `cmd_data`, `cmd_data_valid`, `cmd_lock`) consumed by every voice instance. It accepts one request at a time: SET, SET_FREQ or TOGGLE, with an 8-bit voice mask. For each request it emits a header word followed by that command's payload words, read from an external parameter RAM. While payload words are on the bus it holds `cmd_lock` high, so unselected voices never decode payload as headers.

## Interface
- `PRM_AW`, default 6: parameter RAM address width (62 words used).
- `clk37`  in  1  system clock, 36.864 MHz; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle, request accepted when `req_valid && req_ready`.
- `req_kind`  in  4  command code: 1 = SET, 2 = TOGGLE, 3 = SET_FREQ.
- `req_voices`  in  8  target voice mask.
- `prm_addr`  out  `PRM_AW`  parameter RAM read address.
- `prm_data`  in  32  RAM read data, valid exactly one cycle after `prm_addr`.
- `cmd_data`  out  32  command bus word.
- `cmd_data_valid`  out  1  word qualifier; one word per high cycle.
- `cmd_lock`  out  1  high = voices must not decode a header.
- `busy`  out  1  frame in progress (`!req_ready`).

## Operation
- Header word layout: `{kind[7:0], voices[7:0], 16'h0000}`.
- SET payload: 56 words, RAM addresses 0..55, in this order:
  - at_time[0..5], at_inc, de_time, de_inc, su_time, su_lvl, re_time, re_inc, amplitude (6 words each, operator 0 first);
  - then modin_1 and modin_2.
- SET_FREQ payload: 6 words, RAM addresses 56..61, freq[0..5].
- TOGGLE: header only. Sent even with mask 0, since mask 0 releases all voices.
- SET or SET_FREQ with mask 0, and any other `req_kind`: accepted and dropped. No bus activity; `req_ready` returns the next cycle.
- `cmd_lock` is 0 only in the header cycle. It is 1 in every other cycle, including idle.
- States:
  - IDLE: on accept, go to HDR; or back to IDLE if the request is dropped.
  - HDR: emit header; go to PAY, or to IDLE if TOGGLE.
  - PAY: emit words until the word counter reaches len−1, then go to IDLE.
  - GAP: present only with the pacing macro.
- Word counter: 6 bits, cleared on accept. It never wraps: maximum value 55.

## Timing
- Reset values:
  - `req_ready` = 1, `busy` = 0;
  - `cmd_data_valid` = 0, `cmd_data` = 0, `cmd_lock` = 1, `prm_addr` = 0;
  - state IDLE.
- Accept at cycle T:
  - header is on the bus at T+1 with `cmd_lock` = 0;
  - `prm_addr` = first payload address at T+1;
  - payload word k appears at T+2+k with `cmd_lock` = 1.
- SET frame: last word at T+57, `req_ready` = 1 at T+58. SET_FREQ: last word at T+7, ready at T+8. TOGGLE: ready at T+2.
- Back-to-back requests therefore have exactly one idle bus cycle between frames.
- All outputs are registered. `cmd_data` holds its last value when `cmd_data_valid` = 0.
- `req_*` is sampled only in the accept cycle; changes during a frame are ignored.
- Reset mid-frame: the frame is abandoned immediately. Voices must be reset alongside this block, because a voice left mid-frame would mis-count.

## Configuration
- `VOICE_CMD_TX_PACE_EN`: adds input `gap` (8 bits).
  - After every emitted word (header and payload), the block inserts `gap` cycles with `cmd_data_valid` = 0 and `cmd_lock` = 1, in state GAP.
  - `prm_addr` is issued one cycle before each word is emitted.
  - `gap` is sampled on accept. `gap` = 0 is identical to the non-paced build.
- Without the macro: no `gap` port, no GAP state, back-to-back timing as above.

## Structure
- Shared package `voice_cmd_pkg`:
  - command codes NOP = 0, SET_CMD = 1, TOGGLE_VC = 2, SET_FREQ_CMD = 3;
  - SET_LEN = 56, FREQ_LEN = 6, FREQ_BASE = 56;
  - tx state enum;
  - header packing function.
- Receivers use the same package constants.
- No sub-module is natural: the counter, address generation and FSM are inline.

## Test plan
- SET, mask 8'h05, RAM[i] = 32'hA000_0000 + i:
  - header 32'h0105_0000 with lock 0;
  - then 56 words A000_0000..A000_0037, lock 1, contiguous;
  - `req_ready` high 57 cycles after header.
- SET_FREQ, mask 8'h01, RAM[56..61] = 1230329..1230334 → header 32'h0301_0000, then 6 words in order; a voice model captures freq[0..5] correctly.
- TOGGLE with mask 8'h00, then TOGGLE with 8'h02 → two headers 32'h0200_0000 and 32'h0202_0000, with exactly one idle cycle between them.
- SET with mask 0, and kind 4'h7 → no `cmd_data_valid`, `req_ready` deasserts for exactly one cycle.
- Assert `rst_n` low at payload word 20 of a SET → `cmd_data_valid` = 0 and `cmd_lock` = 1 immediately; a new request after reset produces a clean frame.
- (`VOICE_CMD_TX_PACE_EN`, gap = 3) SET_FREQ → 7 words spaced 4 cycles apart, lock 1 in all gaps, ready 4 cycles after the last word.

Source files
------------

// File: rtl/voice_cmd_pkg.sv
// Shared constants, command codes, state encoding and header packing for the voice command bus.
// The optional pacing build (VOICE_CMD_TX_PACE_EN) adds the TX_GAP state.
package voice_cmd_pkg;

    typedef enum logic [3:0] {
        NOP          = 4'd0,
        SET_CMD      = 4'd1,
        TOGGLE_VC    = 4'd2,
        SET_FREQ_CMD = 4'd3
    } cmd_kind_e;

    localparam int unsigned SET_LEN   = 56;
    localparam int unsigned FREQ_LEN  = 6;
    localparam int unsigned FREQ_BASE = 56;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_PAY  = 2'd2
`ifdef VOICE_CMD_TX_PACE_EN
        , TX_GAP = 2'd3
`endif
    } tx_state_e;

    function automatic logic [31:0] pack_header(input logic [3:0] kind, input logic [7:0] voices);
        return {4'h0, kind, voices, 16'h0000};
    endfunction

endpackage

// File: rtl/voice_cmd_tx.sv
// Voice command bus transmitter: header word then payload words streamed from the parameter RAM.
// Define VOICE_CMD_TX_PACE_EN to add the `gap` input and idle cycles after every emitted word.
module voice_cmd_tx
    import voice_cmd_pkg::*;
#(
    parameter int PRM_AW = 6
) (
    input  logic              clk37,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [7:0]        req_voices,
`ifdef VOICE_CMD_TX_PACE_EN
    input  logic [7:0]        gap,
`endif
    output logic [PRM_AW-1:0] prm_addr,
    input  logic [31:0]       prm_data,
    output logic [31:0]       cmd_data,
    output logic              cmd_data_valid,
    output logic              cmd_lock,
    output logic              busy
);

    tx_state_e         r_state, w_state;
    logic              r_ready, w_ready;
    logic              r_busy;
    logic              r_valid, w_valid;
    logic [31:0]       r_data, w_data;
    logic              r_lock, w_lock;
    logic [PRM_AW-1:0] r_addr, w_addr;
    logic [5:0]        r_cnt, w_cnt;
    logic [5:0]        r_len, w_len;
    logic              r_in_pay, w_in_pay;
    logic              w_adv;
    logic              w_last;
    logic              w_accept;
    logic              w_hdr_ok;
    logic [5:0]        w_sel_len;
    logic [PRM_AW-1:0] w_sel_base;
`ifdef VOICE_CMD_TX_PACE_EN
    logic [7:0]        r_gap, w_gap;
    logic [7:0]        r_gcnt, w_gcnt;
`endif

    // r_ready is only ever high in IDLE, so it doubles as the accept gate.
    assign w_accept = req_valid && r_ready;
    // r_cnt indexes the payload word last put on the bus; r_len of 0 means header-only.
    assign w_last   = r_in_pay ? (r_cnt == (r_len - 6'd1)) : (r_len == 6'd0);

    // Request decode: frame length, RAM base address and whether a header is sent at all.
    always_comb begin
        w_hdr_ok   = 1'b0;
        w_sel_len  = 6'd0;
        w_sel_base = {PRM_AW{1'b0}};
        case (req_kind)
            SET_CMD: begin
                w_hdr_ok  = (req_voices != 8'h00);
                w_sel_len = 6'(SET_LEN);
            end
            SET_FREQ_CMD: begin
                w_hdr_ok   = (req_voices != 8'h00);
                w_sel_len  = 6'(FREQ_LEN);
                w_sel_base = PRM_AW'(FREQ_BASE);
            end
            TOGGLE_VC: begin
                w_hdr_ok = 1'b1;
            end
            default: begin
                w_hdr_ok = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; prm_data is sampled on the edge after prm_addr is driven.
    always_comb begin
        w_state  = r_state;
        w_ready  = r_ready;
        w_valid  = 1'b0;
        w_data   = r_data;
        w_lock   = 1'b1;
        w_addr   = r_addr;
        w_cnt    = r_cnt;
        w_len    = r_len;
        w_in_pay = r_in_pay;
        w_adv    = 1'b0;
`ifdef VOICE_CMD_TX_PACE_EN
        w_gap    = r_gap;
        w_gcnt   = r_gcnt;
`endif
        case (r_state)
            TX_IDLE: begin
                if (w_accept) begin
                    w_ready  = 1'b0;
                    w_cnt    = 6'd0;
                    w_in_pay = 1'b0;
                    w_len    = w_sel_len;
                    w_addr   = w_sel_base;
`ifdef VOICE_CMD_TX_PACE_EN
                    w_gap    = gap;
`endif
                    if (w_hdr_ok) begin
                        w_state = TX_HDR;
                        w_valid = 1'b1;
                        w_data  = pack_header(req_kind, req_voices);
                        w_lock  = 1'b0;
                    end else begin
                        w_state = TX_IDLE;
                    end
                end else begin
                    w_ready = 1'b1;
                end
            end
            TX_HDR, TX_PAY: begin
`ifdef VOICE_CMD_TX_PACE_EN
                if (r_gap != 8'd0) begin
                    w_state = TX_GAP;
                    w_gcnt  = r_gap - 8'd1;
                end else begin
                    w_adv = 1'b1;
                end
`else
                w_adv = 1'b1;
`endif
            end
`ifdef VOICE_CMD_TX_PACE_EN
            TX_GAP: begin
                if (r_gcnt != 8'd0) begin
                    w_gcnt = r_gcnt - 8'd1;
                end else begin
                    w_adv = 1'b1;
                end
            end
`endif
            default: begin
                w_state = TX_IDLE;
                w_ready = 1'b1;
            end
        endcase

        if (w_adv) begin
            if (w_last) begin
                w_state = TX_IDLE;
                w_ready = 1'b1;
            end else begin
                w_state  = TX_PAY;
                w_valid  = 1'b1;
                w_data   = prm_data;
                w_in_pay = 1'b1;
                w_addr   = r_addr + {{(PRM_AW-1){1'b0}}, 1'b1};
                w_cnt    = r_in_pay ? (r_cnt + 6'd1) : r_cnt;
            end
        end else begin
            w_state = w_state;
        end
    end

    // State and output registers.
    always_ff @(posedge clk37 or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= TX_IDLE;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= 32'h0000_0000;
            r_lock   <= 1'b1;
            r_addr   <= {PRM_AW{1'b0}};
            r_cnt    <= 6'd0;
            r_len    <= 6'd0;
            r_in_pay <= 1'b0;
`ifdef VOICE_CMD_TX_PACE_EN
            r_gap    <= 8'd0;
            r_gcnt   <= 8'd0;
`endif
        end else begin
            r_state  <= w_state;
            r_ready  <= w_ready;
            r_busy   <= !w_ready;
            r_valid  <= w_valid;
            r_data   <= w_data;
            r_lock   <= w_lock;
            r_addr   <= w_addr;
            r_cnt    <= w_cnt;
            r_len    <= w_len;
            r_in_pay <= w_in_pay;
`ifdef VOICE_CMD_TX_PACE_EN
            r_gap    <= w_gap;
            r_gcnt   <= w_gcnt;
`endif
        end
    end

    assign req_ready      = r_ready;
    assign busy           = r_busy;
    assign cmd_data_valid = r_valid;
    assign cmd_data       = r_data;
    assign cmd_lock       = r_lock;
    assign prm_addr       = r_addr;

endmodule

// File: tb/tb_voice_cmd_tx.sv
// Scoreboard bench for voice_cmd_tx: a frame model queues expected words with their bus cycle,
// and a monitor on the falling edge pops and compares every presented word.
`timescale 1ns/1ps
module tb_voice_cmd_tx;

    logic        clk37 = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [7:0]  req_voices;
`ifdef VOICE_CMD_TX_PACE_EN
    logic [7:0]  gap;
`endif
    logic [5:0]  prm_addr;
    logic [31:0] prm_data;
    logic [31:0] cmd_data;
    logic        cmd_data_valid;
    logic        cmd_lock;
    logic        busy;

    logic [31:0] ram [64];
    assign prm_data = ram[prm_addr];

    typedef struct {
        logic [31:0] data;
        bit          hdr;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_data = 32'h0;
    logic [31:0] vm_freq [6];
    int          vm_left = 0;

    voice_cmd_tx #(.PRM_AW(6)) dut (
        .clk37          (clk37),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_kind       (req_kind),
        .req_voices     (req_voices),
`ifdef VOICE_CMD_TX_PACE_EN
        .gap            (gap),
`endif
        .prm_addr       (prm_addr),
        .prm_data       (prm_data),
        .cmd_data       (cmd_data),
        .cmd_data_valid (cmd_data_valid),
        .cmd_lock       (cmd_lock),
        .busy           (busy)
    );

    always #5 clk37 = ~clk37;

    always @(posedge clk37) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every falling edge, check the bus against the head of the expected queue.
    always @(negedge clk37) begin
        if (!rst_n) begin
            last_data = 32'h0;
            vm_left   = 0;
        end else begin
            chk("busy_vs_ready", {31'h0, busy}, {31'h0, !req_ready});
            if (cmd_data_valid) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected no word (cycle %0d)", cmd_data, cyc);
                end else begin
                    me = q.pop_front();
                    chk("word_data", cmd_data, me.data);
                    chk("word_lock", {31'h0, cmd_lock}, {31'h0, !me.hdr});
                    chk("word_cycle", 32'(cyc), 32'(me.cyc));
                end
                last_data = cmd_data;
                if (!cmd_lock) begin
                    vm_left = (cmd_data[31:24] == 8'h03 && cmd_data[16]) ? 6 : 0;
                end else if (vm_left > 0) begin
                    vm_freq[6 - vm_left] = cmd_data;
                    vm_left--;
                end
            end else begin
                chk("idle_lock", {31'h0, cmd_lock}, 32'h1);
                chk("idle_hold", cmd_data, last_data);
            end
        end
    end

    // Issue one request at a falling edge with ready high and queue the frame it must produce.
    task automatic send(input logic [3:0] k, input logic [7:0] v, input int g);
        int   t, n, base, w, exp_rdy;
        exp_t e;
        w = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk37);
            w++;
        end
        chk("ready_before_req", {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_kind   = k;
        req_voices = v;
`ifdef VOICE_CMD_TX_PACE_EN
        gap        = g[7:0];
`endif
        t    = cyc;
        n    = 0;
        base = 0;
        if (k == 4'd2) begin
            n = 1;
        end else if (k == 4'd1 && v != 8'h00) begin
            n = 57;
        end else if (k == 4'd3 && v != 8'h00) begin
            n    = 7;
            base = 56;
        end
        for (int j = 0; j < n; j++) begin
            e.hdr  = (j == 0);
            e.data = (j == 0) ? {4'h0, k, v, 16'h0000} : ram[base + j - 1];
            e.cyc  = t + 1 + j * (g + 1);
            q.push_back(e);
        end
        @(posedge clk37);
        #1;
        req_valid  = 1'b0;
        req_kind   = 4'($urandom);
        req_voices = 8'($urandom);
`ifdef VOICE_CMD_TX_PACE_EN
        gap        = 8'($urandom);
`endif
        exp_rdy = (n == 0) ? t + 2 : t + 1 + n * (g + 1);
        w = 0;
        @(negedge clk37);
        while (!req_ready && w < 3000) begin
            @(negedge clk37);
            w++;
        end
        chk("ready_cycle", 32'(cyc), 32'(exp_rdy));
        chk("frame_drained", 32'(q.size()), 32'h0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_valid", {31'h0, cmd_data_valid}, 32'h0);
        chk("rst_data", cmd_data, 32'h0);
        chk("rst_lock", {31'h0, cmd_lock}, 32'h1);
        chk("rst_prm_addr", {26'h0, prm_addr}, 32'h0);
    endtask

    initial begin
        int g;
        exp_t e;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_kind   = 4'h0;
        req_voices = 8'h00;
`ifdef VOICE_CMD_TX_PACE_EN
        gap        = 8'd0;
`endif
        for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + 32'(i);
        repeat (3) @(negedge clk37);
        chk_reset_outputs();
        #2 rst_n = 1'b1;
        @(negedge clk37);

        send(4'd1, 8'h05, 0);
        for (int i = 0; i < 6; i++) ram[56 + i] = 32'd1230329 + 32'(i);
        send(4'd3, 8'h01, 0);
        for (int i = 0; i < 6; i++) chk("voice_freq", vm_freq[i], 32'd1230329 + 32'(i));
        send(4'd2, 8'h00, 0);
        send(4'd2, 8'h02, 0);
        send(4'd1, 8'h00, 0);
        send(4'd7, 8'hFF, 0);

        // Reset while payload word 20 of a SET frame is on the bus.
        req_valid  = 1'b1;
        req_kind   = 4'd1;
        req_voices = 8'hFF;
        for (int j = 0; j < 57; j++) begin
            e.hdr  = (j == 0);
            e.data = (j == 0) ? 32'h01FF_0000 : ram[j - 1];
            e.cyc  = cyc + 1 + j;
            q.push_back(e);
        end
        @(posedge clk37);
        #1 req_valid = 1'b0;
        repeat (22) @(negedge clk37);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        chk("words_left_at_reset", 32'(q.size()), 32'd35);
        q.delete();
        repeat (2) @(negedge clk37);
        #2 rst_n = 1'b1;
        @(negedge clk37);
        send(4'd1, 8'h80, 0);

`ifdef VOICE_CMD_TX_PACE_EN
        send(4'd3, 8'h01, 3);
`endif

        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk37);
`ifdef VOICE_CMD_TX_PACE_EN
            g = $urandom_range(0, 3);
`else
            g = 0;
`endif
            send(4'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), g);
        end

        repeat (3) @(negedge clk37);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
